// File: rtl/multi_channel_delay.sv
// Multi-channel delay line with per-sample valid, an en prescaler, flush,
// and a run-time delay that only changes while the line is empty or flushed.
module multi_channel_delay #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int MAX_DELAY  = 16,
  parameter int TIMING     = 1,
  localparam int SW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           flush,
  input  logic [SW-1:0]                  delay_sel,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           tick,
  output logic [SW-1:0]                  delay_act,
  output logic                           cfg_err
);
  localparam int DW = CHANNELS * DATA_WIDTH;

  function automatic logic [SW-1:0] f_clamp(input logic [SW-1:0] s);
    if (s == '0) return SW'(1);
    if (s > SW'(MAX_DELAY)) return SW'(MAX_DELAY);
    return s;
  endfunction

  function automatic logic f_out_of_range(input logic [SW-1:0] s);
    return (s == '0) || (s > SW'(MAX_DELAY));
  endfunction

  logic                 w_tick;
  logic                 w_shift;
  logic                 w_idle;
  logic [MAX_DELAY-1:0] r_vld;
  logic [DW-1:0]        r_data [MAX_DELAY];
  logic [SW-1:0]        r_delay_act;
  logic                 r_cfg_err;

  // Prescaler: a partial count is discarded whenever en drops or flush fires
  generate
    if (TIMING > 1) begin : g_presc
      localparam int CW = $clog2(TIMING);
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (flush || !en || w_tick) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      assign w_tick = en && (r_cnt == CW'(TIMING - 1));
    end else begin : g_no_presc
      assign w_tick = en;
    end
  endgenerate

  assign tick    = w_tick;
  assign w_shift = w_tick && !flush;
  assign w_idle  = (r_vld == '0);

  // Stage registers: all channels shift together on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < MAX_DELAY; k++) r_data[k] <= '0;
    end else if (flush) begin
      r_vld <= '0;
      for (int k = 0; k < MAX_DELAY; k++) r_data[k] <= '0;
    end else if (w_shift) begin
      r_vld[0]  <= in_valid;
      r_data[0] <= in_data;
      for (int k = 1; k < MAX_DELAY; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end

  // Delay only changes when nothing is in flight, so samples are never reordered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_act <= SW'(1);
      r_cfg_err   <= 1'b0;
    end else if (flush) begin
      r_delay_act <= f_clamp(delay_sel);
      r_cfg_err   <= f_out_of_range(delay_sel);
    end else if (w_idle) begin
      r_delay_act <= f_clamp(delay_sel);
      if (f_out_of_range(delay_sel)) r_cfg_err <= 1'b1;
    end
  end

  assign delay_act = r_delay_act;
  assign cfg_err   = r_cfg_err;

  // Output tap: pure mux of registered stages, so in_data never reaches out_data combinationally
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (r_delay_act == SW'(k + 1)) begin
        out_valid = r_vld[k];
        out_data  = r_data[k];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_delay.sv
// Bench for multi_channel_delay: a TIMING=1 and a TIMING=4 instance, scoreboard
// queues of expected samples with due tick counts, plus a delay-loading table.
module tb_multi_channel_delay;
  localparam int DW = 8;
  localparam int CH = 3;
  localparam int MD = 16;
  localparam int SW = 5;
  localparam int BW = CH * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          en1 = 0, fl1 = 0, iv1 = 0;
  logic [SW-1:0] ds1 = '0;
  logic [BW-1:0] id1 = '0;
  logic          ov1, tk1, ce1;
  logic [BW-1:0] od1;
  logic [SW-1:0] da1;

  logic          en4 = 0, fl4 = 0, iv4 = 0;
  logic [SW-1:0] ds4 = '0;
  logic [BW-1:0] id4 = '0;
  logic          ov4, tk4, ce4;
  logic [BW-1:0] od4;
  logic [SW-1:0] da4;

  multi_channel_delay #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_DELAY(MD), .TIMING(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .flush(fl1), .delay_sel(ds1),
    .in_valid(iv1), .in_data(id1), .out_valid(ov1), .out_data(od1),
    .tick(tk1), .delay_act(da1), .cfg_err(ce1));

  multi_channel_delay #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_DELAY(MD), .TIMING(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .flush(fl4), .delay_sel(ds4),
    .in_valid(iv4), .in_data(id4), .out_valid(ov4), .out_data(od4),
    .tick(tk4), .delay_act(da4), .cfg_err(ce4));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampm(input logic [SW-1:0] s);
    int v;
    v = int'(s);
    if (v < 1) return 1;
    if (v > MD) return MD;
    return v;
  endfunction

  function automatic logic oorm(input logic [SW-1:0] s);
    return (int'(s) < 1) || (int'(s) > MD);
  endfunction

  typedef struct {
    logic [BW-1:0] d;
    int            due;
  } sb_t;

  sb_t  q1[$];
  sb_t  q4[$];
  int   tc1 = 0, live1 = -1, md1 = 1;
  logic me1 = 1'b0;
  int   tc4 = 0, md4 = 1, cnt4 = 0;
  logic ev4 = 1'b0;
  logic [BW-1:0] ed4 = '0;

  typedef struct {
    logic          f;
    logic [SW-1:0] s;
    int            act;
    logic          err;
  } cfg_vec_t;

  cfg_vec_t tbl[9];

  // One clock of the TIMING=1 instance with scoreboard bookkeeping
  task automatic cyc1();
    logic sh;
    logic idle;
    sb_t  e;
    #1;
    chk("tick1", 32'(tk1), 32'(en1));
    sh   = en1 && !fl1;
    idle = (tc1 > live1);
    if (fl1 || idle) begin
      if (fl1) me1 = oorm(ds1);
      else if (oorm(ds1)) me1 = 1'b1;
      md1 = clampm(ds1);
    end
    if (fl1) begin
      q1.delete();
      live1 = -1;
    end
    if (sh && iv1) begin
      e.d   = id1;
      e.due = tc1 + md1;
      q1.push_back(e);
      live1 = tc1 + MD;
    end
    @(posedge clk);
    #1;
    if (sh) tc1++;
    chk("delay_act1", 32'(da1), 32'(md1));
    chk("cfg_err1", 32'(ce1), 32'(me1));
    if (fl1) begin
      chk("flush_vld1", 32'(ov1), 32'(0));
      chk("flush_data1", 32'(od1), 32'(0));
    end else if (sh) begin
      if (q1.size() > 0 && q1[0].due == tc1) begin
        chk("out_vld1", 32'(ov1), 32'(1));
        chk("out_data1", 32'(od1), 32'(q1[0].d));
        void'(q1.pop_front());
      end else begin
        chk("out_idle1", 32'(ov1), 32'(0));
      end
    end
  endtask

  // One clock of the TIMING=4 instance; output is expected to hold between ticks
  task automatic cyc4();
    logic t;
    logic sh;
    sb_t  e;
    #1;
    t = en4 && (cnt4 == 3);
    chk("tick4", 32'(tk4), 32'(t));
    sh = t && !fl4;
    if (fl4) begin
      q4.delete();
      md4 = clampm(ds4);
    end
    if (sh && iv4) begin
      e.d   = id4;
      e.due = tc4 + md4;
      q4.push_back(e);
    end
    cnt4 = (fl4 || !en4 || t) ? 0 : cnt4 + 1;
    @(posedge clk);
    #1;
    if (sh) begin
      tc4++;
      if (q4.size() > 0 && q4[0].due == tc4) begin
        ev4 = 1'b1;
        ed4 = q4[0].d;
        void'(q4.pop_front());
      end else begin
        ev4 = 1'b0;
      end
    end
    if (fl4) ev4 = 1'b0;
    chk("out_vld4", 32'(ov4), 32'(ev4));
    if (ev4) chk("out_data4", 32'(od4), 32'(ed4));
  endtask

  task automatic ramp1(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      id1 = {8'(base + 3 * i + 1), 8'(base + 3 * i + 2), 8'(base + 3 * i + 3)};
      cyc1();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd0,  1,  1'b1};
    tbl[1] = '{1'b1, 5'd20, 16, 1'b1};
    tbl[2] = '{1'b1, 5'd16, 16, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 16, 1'b1};
    tbl[4] = '{1'b1, 5'd7,  7,  1'b0};
    tbl[5] = '{1'b0, 5'd0,  1,  1'b1};
    tbl[6] = '{1'b0, 5'd7,  7,  1'b1};
    tbl[7] = '{1'b1, 5'd7,  7,  1'b0};
    tbl[8] = '{1'b1, 5'd1,  1,  1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", 32'(ov1), 32'(0));
    chk("rst_data", 32'(od1), 32'(0));
    chk("rst_act", 32'(da1), 32'(1));
    chk("rst_err", 32'(ce1), 32'(0));
    chk("rst_tick", 32'(tk1), 32'(0));
    chk("rst_act4", 32'(da4), 32'(1));
    ds1 = 5'd5;
    ds4 = 5'd2;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at delay 5
    fl1 = 1; en1 = 0; iv1 = 0;
    cyc1();
    fl1 = 0; en1 = 1; iv1 = 1;
    ramp1(12, 0);

    // delay_sel change while samples are in flight is ignored
    ds1 = 5'd3;
    ramp1(5, 36);
    chk("hold_delay5", 32'(da1), 32'(5));
    fl1 = 1;
    ramp1(1, 60);
    fl1 = 0;
    chk("flushed_delay3", 32'(da1), 32'(3));
    ramp1(8, 70);

    // Flush coincident with a tick drops the 0xAA sample
    id1 = {CH{8'hAA}};
    fl1 = 1;
    cyc1();
    fl1 = 0;
    ramp1(10, 120);

    // Delay loading and cfg_err table
    en1 = 0; iv1 = 0;
    for (int i = 0; i < 9; i++) begin
      fl1 = tbl[i].f;
      ds1 = tbl[i].s;
      cyc1();
      chk($sformatf("tbl%0d_act", i), 32'(da1), 32'(tbl[i].act));
      chk($sformatf("tbl%0d_err", i), 32'(ce1), 32'(tbl[i].err));
    end
    fl1 = 0;

    // Prescaler at TIMING=4, delay 2, with an en gap at count 2
    fl4 = 1;
    cyc4();
    fl4 = 0; en4 = 1; iv4 = 1;
    for (int i = 0; i < 14; i++) begin
      id4 = BW'(24'h100 + i);
      cyc4();
    end
    en4 = 0;
    cyc4();
    cyc4();
    en4 = 1;
    for (int i = 0; i < 10; i++) begin
      id4 = BW'(24'h200 + i);
      cyc4();
    end
    en4 = 0;

    // Asynchronous reset mid-stream, then restart at delay 1
    ds1 = 5'd4;
    fl1 = 1;
    cyc1();
    fl1 = 0; en1 = 1; iv1 = 1;
    ramp1(7, 150);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(ov1), 32'(0));
    chk("async_data", 32'(od1), 32'(0));
    chk("async_act", 32'(da1), 32'(1));
    ds1 = 5'd1;
    q1.delete();
    live1 = -1;
    md1 = 1;
    me1 = 1'b0;
    #2 rst_n = 1'b1;
    ramp1(4, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
